button_array: RTL and testbench
===============================

BUTTON_ARRAY -- requirements
Module: button_array

Interface
REQ-001 SHALL have parameter N, default 4: number of independent button channels, 1..32.
REQ-002 SHALL have parameter CLK_HZ, default 100_000_000: clk frequency.
REQ-003 SHALL have parameter SAMPLE_HZ, default 100: debounce sample rate; DIV = CLK_HZ/SAMPLE_HZ SHALL be at least 2.
REQ-004 SHALL have parameter STABLE, default 4: consecutive agreeing samples needed to change state, 1..15.
REQ-005 SHALL have parameter ACTIVE_LOW, default 0: 1 means a pressed button reads 0 on btn_in.
REQ-006 SHALL have parameter HOLD_TICKS, default 50: samples held before the first repeat pulse.
REQ-007 SHALL have parameter REPEAT_TICKS, default 10: samples between subsequent repeat pulses.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-010 SHALL have port btn_in, input, N bits: raw asynchronous button pins.
REQ-011 SHALL have port btn_level, output, N bits: debounced pressed state, 1 = pressed.
REQ-012 SHALL have port btn_press, output, N bits: one-cycle pulse on each debounced press.
REQ-013 SHALL have port btn_release, output, N bits: one-cycle pulse on each debounced release.
REQ-014 SHALL have port btn_repeat, output, N bits: one-cycle auto-repeat pulse.
REQ-015 SHALL have port sample_tick, output, 1 bit: one-cycle sample strobe, provided for visibility.

Function
REQ-016 Divider SHALL count 0..DIV-1 and wrap to 0; sample_tick SHALL be high exactly in the cycle where count = DIV-1.
REQ-017 Each bit of btn_in SHALL pass through a 2-flop synchroniser, then be XORed with ACTIVE_LOW to form the sample.
REQ-018 Per channel, on a tick where the sample differs from btn_level, the stability counter SHALL increment; on a tick where they agree it SHALL clear to 0.
REQ-019 The stability counter SHALL NOT change in cycles with no tick.
REQ-020 btn_level SHALL toggle, and the counter SHALL clear, on the tick that gives the STABLE-th consecutive differing sample; with STABLE=1 it toggles on the first differing tick.
REQ-021 Any bounce, i.e. a single agreeing tick, SHALL restart the count; level SHALL never change between ticks.
REQ-022 btn_press/btn_release SHALL be high for exactly the one cycle after btn_level rises or falls, and never together on one channel.
REQ-023 Worst-case latency from a clean btn_in edge to btn_level SHALL be 2 + STABLE*DIV cycles.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycles.

Reset
REQ-025 While rst = 0: divider, stability counters and hold counters SHALL be 0.
REQ-026 While rst = 0: synchroniser flops SHALL hold the released pin value (ACTIVE_LOW), and btn_level SHALL be 0.
REQ-027 While rst = 0: all pulse outputs and sample_tick SHALL be 0.
REQ-028 Releasing reset with a button already held SHALL produce a normal press after STABLE ticks.
REQ-029 Releasing reset with all buttons released SHALL produce no spurious pulse.
REQ-030 Asserting reset mid-debounce or mid-hold SHALL abort it immediately, with no pulse emitted.

Configuration
REQ-031 With macro BUTTON_REPEAT_EN defined, each channel SHALL have a hold counter, incremented on ticks while btn_level = 1 and cleared when btn_level = 0.
REQ-032 With BUTTON_REPEAT_EN defined, btn_repeat SHALL pulse one cycle when the hold count reaches HOLD_TICKS, then every REPEAT_TICKS ticks after that.
REQ-033 With BUTTON_REPEAT_EN defined, the hold counter SHALL saturate-wrap back to HOLD_TICKS, never overflowing.
REQ-034 Without BUTTON_REPEAT_EN, no hold counters SHALL exist and btn_repeat SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-035 A shared package btn_pkg SHALL hold the default constants and a clog2-based counter-width function.
REQ-036 Per-channel logic (synchroniser, stability counter, level, edge pulses, hold counter) SHALL be a sub-module btn_debounce_cell, instantiated N times; the divider is shared at top level.

Verification
All scenarios use CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), STABLE=3, N=4, HOLD_TICKS=5, REPEAT_TICKS=2.
REQ-037 Divider: sample_tick pulses every 10 cycles, first in cycle 9 after reset release.
REQ-038 Clean press: btn_in[0] 0->1 held -> btn_level[0] rises on the 3rd tick after sync, btn_press[0] pulses one cycle, no other channel moves.
REQ-039 Bounce: btn_in[1] toggles 1,0,1,1,1 across ticks -> level rises only after the final 3 agreeing ticks; exactly one press pulse.
REQ-040 ACTIVE_LOW=1: pins idle at 1 with reset released -> no pulses; pin driven 0 -> press; driven back to 1 -> release pulse after 3 ticks.
REQ-041 BUTTON_REPEAT_EN: hold channel 2 for 12 ticks after level rises -> repeat pulses at hold ticks 5, 7, 9, 11; release -> none after.
REQ-042 Reset mid-operation: assert rst at tick 2 of a 3-tick press -> all outputs 0 at once; release rst with button held -> press after 3 ticks.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared defaults and sizing helper for the button debounce array.
// Imported by btn_debounce_cell and button_array.
package btn_pkg;

  localparam int DEF_N            = 4;
  localparam int DEF_CLK_HZ       = 100_000_000;
  localparam int DEF_SAMPLE_HZ    = 100;
  localparam int DEF_STABLE       = 4;
  localparam int DEF_ACTIVE_LOW   = 0;
  localparam int DEF_HOLD_TICKS   = 50;
  localparam int DEF_REPEAT_TICKS = 10;

  // Bits needed to hold values 0..max_val (never less than 1).
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-flop sync, tick-driven debounce, edge pulses,
// optional auto-repeat (macro BUTTON_REPEAT_EN).
// Ports: clk, rst (async active-low), tick_i, pin_i,
//        level_o, press_o, release_o, repeat_o.
module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int STABLE       = DEF_STABLE,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic IDLE = (ACTIVE_LOW != 0);
  localparam int   SW   = cnt_w(STABLE);

  if (STABLE < 1 || STABLE > 15) begin : g_bad_stable
    $error("btn_debounce_cell: STABLE out of range");
  end
  if (HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_hold
    $error("btn_debounce_cell: HOLD/REPEAT_TICKS must be >= 1");
  end

  logic [1:0]    sync_q;
  logic          sample;
  logic [SW-1:0] stab_q, stab_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  assign sample = sync_q[1] ^ IDLE;

  always_comb begin
    stab_d  = stab_q;
    level_d = level_q;
    if (tick_i) begin
      if (sample != level_q) begin
        if (stab_q == SW'(STABLE - 1)) begin
          stab_d  = '0;
          level_d = ~level_q;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end else begin
        stab_d = '0;
      end
    end
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {2{IDLE}};
      stab_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      stab_q  <= stab_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef BUTTON_REPEAT_EN
  localparam int HW = cnt_w(HOLD_TICKS + REPEAT_TICKS);

  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          rep_q, rep_d;

  // Past the first repeat the count folds back onto HOLD_TICKS,
  // so every REPEAT_TICKS-th tick lands on the pulse value again.
  always_comb begin
    hold_inc = hold_q + HW'(1);
    hold_d   = hold_q;
    rep_d    = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (tick_i) begin
      if (hold_inc == HW'(HOLD_TICKS + REPEAT_TICKS))
        hold_d = HW'(HOLD_TICKS);
      else
        hold_d = hold_inc;
      rep_d = (hold_d == HW'(HOLD_TICKS));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_array.sv
// N-channel button debouncer with shared sample divider.
// Ports: clk, rst (async active-low), btn_in[N], btn_level/press/
//        release/repeat[N], sample_tick. Repeat needs BUTTON_REPEAT_EN.
module button_array
  import btn_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int SAMPLE_HZ    = DEF_SAMPLE_HZ,
  parameter int STABLE       = DEF_STABLE,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_repeat,
  output logic         sample_tick
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DW  = cnt_w(DIV - 1);

  if (N < 1 || N > 32) begin : g_bad_n
    $error("button_array: N out of range");
  end
  if (DIV < 2) begin : g_bad_div
    $error("button_array: CLK_HZ/SAMPLE_HZ must be >= 2");
  end

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  assign tick  = (div_q == DW'(DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

  assign sample_tick = tick;

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_debounce_cell #(
      .STABLE      (STABLE),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .pin_i    (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_array.sv
// Scoreboard bench for button_array: DIV=10, STABLE=3, HOLD=5, REPEAT=2.
// Two instances: active-high (a) and active-low (b) pins.
module tb_button_array;

  typedef struct {
    int       tick;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
    logic [3:0] level;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_a, btn_b;
  logic [3:0] lvl_a, prs_a, rel_a, rep_a;
  logic [3:0] lvl_b, prs_b, rel_b, rep_b;
  logic       tick_a, tick_b;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  tick_n  = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;

  button_array #(
    .N(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE(3),
    .ACTIVE_LOW(0), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_a),
    .btn_level(lvl_a), .btn_press(prs_a),
    .btn_release(rel_a), .btn_repeat(rep_a),
    .sample_tick(tick_a)
  );

  button_array #(
    .N(4), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE(3),
    .ACTIVE_LOW(1), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_b),
    .btn_level(lvl_b), .btn_press(prs_b),
    .btn_release(rel_b), .btn_repeat(rep_b),
    .sample_tick(tick_b)
  );

  always @(posedge clk)
    if (tick_a) tick_n <= tick_n + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_ev(input string nm, input ev_t e,
                        input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] rp, input logic [3:0] l);
    n_tests++;
    if (e.tick != tick_n || e.press !== p || e.rel !== r ||
        e.rep !== rp || e.level !== l) begin
      n_fail++;
      $display("FAIL %s: got tick=%0d prs=%b rel=%b rep=%b lvl=%b expected tick=%0d prs=%b rel=%b rep=%b lvl=%b",
               nm, tick_n, p, r, rp, l,
               e.tick, e.press, e.rel, e.rep, e.level);
    end
  endtask

  always @(negedge clk)
    if (rst && (prs_a | rel_a | rep_a) != 4'b0) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_a: got tick=%0d prs=%b rel=%b rep=%b expected no pulse",
                 tick_n, prs_a, rel_a, rep_a);
      end else begin
        cmp_ev("event_a", qa.pop_front(), prs_a, rel_a, rep_a, lvl_a);
      end
    end

  always @(negedge clk)
    if (rst && (prs_b | rel_b | rep_b) != 4'b0) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_b: got tick=%0d prs=%b rel=%b rep=%b expected no pulse",
                 tick_n, prs_b, rel_b, rep_b);
      end else begin
        cmp_ev("event_b", qb.pop_front(), prs_b, rel_b, rep_b, lvl_b);
      end
    end

  function automatic void exp_a(input int t, input logic [3:0] p,
      input logic [3:0] r, input logic [3:0] rp, input logic [3:0] l);
    ev_t e;
    e.tick = t; e.press = p; e.rel = r; e.rep = rp; e.level = l;
    qa.push_back(e);
  endfunction

  function automatic void exp_b(input int t, input logic [3:0] p,
      input logic [3:0] r, input logic [3:0] rp, input logic [3:0] l);
    ev_t e;
    e.tick = t; e.press = p; e.rel = r; e.rep = rp; e.level = l;
    qb.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge just after a tick edge.
  task automatic wait_tick();
    int k;
    k = 0;
    while (!tick_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick in %0d cycles expected one", k);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_lvl_a"}, int'(lvl_a), 0);
    check({nm, "_prs_a"}, int'(prs_a), 0);
    check({nm, "_rel_a"}, int'(rel_a), 0);
    check({nm, "_rep_a"}, int'(rep_a), 0);
    check({nm, "_lvl_b"}, int'(lvl_b), 0);
    check({nm, "_tick"}, int'(tick_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    rst   = 1'b0;
    btn_a = 4'b0000;
    btn_b = 4'b1111;
    repeat (3) @(negedge clk);
    check_zero("reset");

    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check("tick_period", int'(tick_a), (k % 10 == 9) ? 1 : 0);
    end

    // clean press / release on channel 0
    wait_tick();
    btn_a = 4'b0001;
    exp_a(tick_n + 3, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    repeat (4) wait_tick();
    btn_a = 4'b0000;
    exp_a(tick_n + 3, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (4) wait_tick();

    // bounce on channel 1: 1,0,1,1,1
    btn_a = 4'b0010;
    wait_tick();
    btn_a = 4'b0000;
    wait_tick();
    btn_a = 4'b0010;
    exp_a(tick_n + 3, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    repeat (3) wait_tick();
    btn_a = 4'b0000;
    exp_a(tick_n + 3, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    repeat (4) wait_tick();

    // simultaneous channels 0 and 3
    btn_a = 4'b1001;
    exp_a(tick_n + 3, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    repeat (4) wait_tick();
    btn_a = 4'b0000;
    exp_a(tick_n + 3, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    repeat (4) wait_tick();

    // long hold on channel 2
    btn_a = 4'b0100;
    l0 = tick_n + 3;
    exp_a(l0, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
`ifdef BUTTON_REPEAT_EN
    for (int k = 5; k <= 11; k += 2)
      exp_a(l0 + k, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
    repeat (12) wait_tick();
    btn_a = 4'b0000;
    exp_a(l0 + 12, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    repeat (6) wait_tick();

    // active-low instance, channel 0
    btn_b = 4'b1110;
    exp_b(tick_n + 3, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    repeat (3) wait_tick();
    btn_b = 4'b1111;
    exp_b(tick_n + 3, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (4) wait_tick();

    // reset mid-hold (ch1) and mid-debounce (ch0)
    btn_a = 4'b0010;
    exp_a(tick_n + 3, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    repeat (3) wait_tick();
    btn_a = 4'b0011;
    repeat (2) wait_tick();
    rst = 1'b0;
    #1;
    check_zero("abort");
    repeat (4) @(negedge clk);
    check_zero("abort_hold");
    rst = 1'b1;
    exp_a(tick_n + 3, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
    repeat (3) wait_tick();
    btn_a = 4'b0000;
    exp_a(tick_n + 3, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
    repeat (6) wait_tick();

    check("queue_a_empty", qa.size(), 0);
    check("queue_b_empty", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
